// File: rtl/change_dispenser_pkg.sv
// change_pkg: shared coin encoding, denomination values, FSM states and widths.
package change_pkg;
    localparam int CHANGE_W = 7;
    typedef enum logic [1:0] {COIN_1, COIN_5, COIN_10, COIN_50} coin_t;
    typedef enum logic [1:0] {IDLE, SELECT, DISPENSE, DONE} state_t;
    localparam logic [5:0] COIN_VALUE [4] = '{6'd1, 6'd5, 6'd10, 6'd50};
endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request, refill, hopper handshake and status signals of the dispenser.
interface change_dispenser_if import change_pkg::*; #(parameter int STOCK_W = 6);
    logic                changeValid;
    logic [CHANGE_W-1:0] changeAmount;
    logic                refill;
    logic [1:0]          refillCoin;
    logic [STOCK_W-1:0]  refillCount;
    logic                coinAck;
    logic                coinValid;
    logic [1:0]          coinType;
    logic [5:0]          coinValue;
    logic                busy;
    logic [CHANGE_W-1:0] remaining;
    logic                done;
    logic                fault;
    logic [3:0]          emptyMask;
    modport master (
        output changeValid, changeAmount, refill, refillCoin, refillCount, coinAck,
        input  coinValid, coinType, coinValue, busy, remaining, done, fault, emptyMask
    );
    modport slave (
        input  changeValid, changeAmount, refill, refillCoin, refillCount, coinAck,
        output coinValid, coinType, coinValue, busy, remaining, done, fault, emptyMask
    );
endinterface

// File: rtl/change_dispenser_coin_select.sv
// coin_select: greedy pick of the largest in-stock denomination not exceeding the amount left.
module coin_select import change_pkg::*; (
    input  logic [CHANGE_W-1:0] remaining,
    input  logic [3:0]          avail,
    output logic                found,
    output coin_t               coinType
);
    logic [3:0] ok;
    always_comb begin
        for (int i = 0; i < 4; i++) ok[i] = avail[i] && ({1'b0, COIN_VALUE[i]} <= remaining);
        found = |ok;
        coinType = ok[3] ? COIN_50 : ok[2] ? COIN_10 : ok[1] ? COIN_5 : COIN_1;
    end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out change one coin at a time from a per-denomination inventory,
// flagging a fault with the shortfall left in remaining when exact change is impossible.
module change_dispenser import change_pkg::*; #(
    parameter int INIT_STOCK = 10,
    parameter int STOCK_W    = 6
) (
    input logic clk,
    input logic reset,
    change_dispenser_if.slave bus
);
    state_t              state, state_n;
    coin_t               sel_n, pick;
    logic                found;
    logic [CHANGE_W-1:0] rem_n;
    logic [STOCK_W-1:0]  stock [4];
    logic [STOCK_W-1:0]  stock_n [4];
    logic [STOCK_W:0]    sum;
    // emptyMask mirrors stock==0, so its complement is the in-stock flag set
    coin_select u_select (
        .remaining(bus.remaining),
        .avail(~bus.emptyMask),
        .found(found),
        .coinType(pick)
    );
    always_comb begin
        state_n = state;
        rem_n = bus.remaining;
        sel_n = coin_t'(bus.coinType);
        stock_n = stock;
        sum = {1'b0, stock[bus.refillCoin]} + {1'b0, bus.refillCount};
        case (state)
            IDLE:
                if (bus.changeValid) begin
                    state_n = SELECT;
                    rem_n = bus.changeAmount;
                end else if (bus.refill) begin
                    stock_n[bus.refillCoin] = sum[STOCK_W] ? '1 : sum[STOCK_W-1:0];
                end
            SELECT: begin
                state_n = found ? DISPENSE : DONE;
                sel_n = found ? pick : sel_n;
            end
            DISPENSE:
                if (bus.coinAck && bus.coinValid) begin
                    state_n = SELECT;
                    rem_n = bus.remaining - {1'b0, COIN_VALUE[bus.coinType]};
                    stock_n[bus.coinType] = stock[bus.coinType] - 1'b1;
                end
            DONE: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            bus.remaining <= '0;
            bus.coinType <= COIN_1;
            bus.coinValue <= COIN_VALUE[COIN_1];
            bus.coinValid <= 1'b0;
            bus.done <= 1'b0;
            bus.fault <= 1'b0;
            bus.busy <= 1'b0;
            bus.emptyMask <= (INIT_STOCK == 0) ? 4'b1111 : 4'b0000;
            for (int i = 0; i < 4; i++) stock[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            state <= state_n;
            bus.remaining <= rem_n;
            bus.coinType <= sel_n;
            bus.coinValue <= COIN_VALUE[sel_n];
            bus.coinValid <= state_n == DISPENSE;
            bus.done <= state_n == DONE;
            bus.fault <= (state_n == DONE) && (rem_n != '0);
            bus.busy <= state_n != IDLE;
            for (int i = 0; i < 4; i++) begin
                stock[i] <= stock_n[i];
                bus.emptyMask[i] <= stock_n[i] == '0;
            end
        end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scoreboard bench; expected coins are queued at request time and
// popped as the hopper acknowledges each coin.
module tb_change_dispenser;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    int q[$];
    int q1[$];
    int mstock[4];
    int exp_rem;
    int lat;
    int vals[4] = '{1, 5, 10, 50};

    always #5 clk = ~clk;

    change_dispenser_if #(.STOCK_W(6)) bus ();
    change_dispenser_if #(.STOCK_W(6)) bus1 ();

    change_dispenser #(.INIT_STOCK(10), .STOCK_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));
    change_dispenser #(.INIT_STOCK(1), .STOCK_W(6)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(negedge clk)
        if (bus.coinValid && bus.coinAck) begin
            if (q.size() == 0) chk("coin_extra", int'(bus.coinType), -1);
            else begin
                chk("coin_type", int'(bus.coinType), q[0]);
                chk("coin_value", int'(bus.coinValue), vals[q[0]]);
                void'(q.pop_front());
            end
        end

    always @(negedge clk)
        if (bus1.coinValid && bus1.coinAck) begin
            if (q1.size() == 0) chk("coin1_extra", int'(bus1.coinType), -1);
            else chk("coin1_type", int'(bus1.coinType), q1.pop_front());
        end

    task automatic push_greedy(input int amt);
        int r = amt;
        int d;
        do begin
            d = -1;
            for (int i = 3; i >= 0; i--)
                if (d < 0 && mstock[i] > 0 && vals[i] <= r) d = i;
            if (d >= 0) begin
                q.push_back(d);
                r -= vals[d];
                mstock[d]--;
            end
        end while (d >= 0);
        exp_rem = r;
    endtask

    task automatic do_req(input int amt);
        @(posedge clk) #1;
        bus.changeValid = 1'b1;
        bus.changeAmount = 7'(amt);
        push_greedy(amt);
        @(posedge clk) #1;
        bus.changeValid = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            l++;
            if (bus.done) return;
        end
        chk("done_timeout", 0, 1);
        l = -1;
    endtask

    task automatic wait_coin();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.coinValid) return;
        end
        chk("coin_timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        @(posedge clk) #1;
        reset = 1'b1;
        @(posedge clk) #1;
        reset = 1'b0;
        q.delete();
        q1.delete();
        for (int i = 0; i < 4; i++) mstock[i] = 10;
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_fault"}, int'(bus.fault), exp_rem != 0 ? 1 : 0);
        chk({tag, "_rem"}, int'(bus.remaining), exp_rem);
        chk({tag, "_qempty"}, q.size(), 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, int'(bus.done), 0);
        chk({tag, "_idle"}, int'(bus.busy), 0);
    endtask

    initial begin
        int cnt;
        bus.changeValid = 0; bus.changeAmount = 0; bus.refill = 0;
        bus.refillCoin = 0; bus.refillCount = 0; bus.coinAck = 1;
        bus1.changeValid = 0; bus1.changeAmount = 0; bus1.refill = 0;
        bus1.refillCoin = 0; bus1.refillCount = 0; bus1.coinAck = 1;
        for (int i = 0; i < 4; i++) mstock[i] = 10;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", int'(bus.coinValid), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_fault", int'(bus.fault), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_rem", int'(bus.remaining), 0);
        chk("rst_type", int'(bus.coinType), 0);
        chk("rst_value", int'(bus.coinValue), 1);
        chk("rst_empty", int'(bus.emptyMask), 0);
        chk("rst_stock50", int'(dut.stock[3]), 10);
        chk("rst1_empty", int'(bus1.emptyMask), 0);

        // single coin, immediate ack
        do_req(5);
        wait_done(lat);
        chk("c5_latency", lat, 5);
        check_done("c5");
        chk("c5_stock5", int'(dut.stock[1]), 9);

        // zero change with a simultaneous refill: request wins, refill dropped
        @(posedge clk) #1;
        bus.refill = 1'b1; bus.refillCoin = 2'd3; bus.refillCount = 6'd1;
        bus.changeValid = 1'b1; bus.changeAmount = 7'd0;
        push_greedy(0);
        @(posedge clk) #1;
        bus.changeValid = 1'b0; bus.refill = 1'b0;
        wait_done(lat);
        chk("c0_latency", lat, 3);
        check_done("c0");
        chk("c0_refill_dropped", int'(dut.stock[3]), 10);

        // 78 from default stock
        pulse_reset();
        @(negedge clk);
        chk("rst_stock5_back", int'(dut.stock[1]), 10);
        do_req(78);
        chk("c78_qlen", q.size(), 7);
        wait_done(lat);
        check_done("c78");
        chk("c78_stock50", int'(dut.stock[3]), 9);
        chk("c78_stock10", int'(dut.stock[2]), 8);
        chk("c78_stock5", int'(dut.stock[1]), 9);
        chk("c78_stock1", int'(dut.stock[0]), 7);

        // ack withheld for 3 cycles
        @(posedge clk) #1 bus.coinAck = 1'b0;
        do_req(10);
        wait_coin();
        for (int k = 0; k < 3; k++) begin
            chk("stall_valid", int'(bus.coinValid), 1);
            chk("stall_type", int'(bus.coinType), 2);
            chk("stall_stock10", int'(dut.stock[2]), 8);
            if (k < 2) @(negedge clk);
        end
        @(posedge clk) #1 bus.coinAck = 1'b1;
        wait_done(lat);
        check_done("stall");
        chk("stall_one_dec", int'(dut.stock[2]), 7);

        // reset while a coin is presented mid-78
        pulse_reset();
        do_req(78);
        cnt = 0;
        for (int i = 0; i < 50 && !(bus.coinValid && bus.remaining == 7'd28); i++) @(negedge clk);
        chk("mid_reached", int'(bus.remaining), 28);
        chk("mid_stock50", int'(dut.stock[3]), 9);
        reset = 1'b1;
        @(posedge clk) #1;
        q.delete();
        @(negedge clk);
        chk("mid_valid_low", int'(bus.coinValid), 0);
        chk("mid_busy_low", int'(bus.busy), 0);
        @(posedge clk) #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) mstock[i] = 10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
        chk("mid_no_done", cnt, 0);
        for (int i = 0; i < 4; i++) chk("mid_stock_back", int'(dut.stock[i]), 10);

        // INIT_STOCK = 1: shortfall
        @(posedge clk) #1;
        bus1.changeValid = 1'b1; bus1.changeAmount = 7'd20;
        q1.push_back(2); q1.push_back(1); q1.push_back(0);
        @(posedge clk) #1 bus1.changeValid = 1'b0;
        cnt = 0;
        while (!bus1.done && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("s1_done", int'(bus1.done), 1);
        chk("s1_fault", int'(bus1.fault), 1);
        chk("s1_rem", int'(bus1.remaining), 4);
        chk("s1_empty", int'(bus1.emptyMask), 7);
        chk("s1_qempty", q1.size(), 0);
        @(posedge clk) #1;
        bus1.refill = 1'b1; bus1.refillCoin = 2'd0; bus1.refillCount = 6'd3;
        @(posedge clk) #1 bus1.refill = 1'b0;
        @(negedge clk);
        chk("s1_refill_empty", int'(bus1.emptyMask), 6);
        chk("s1_shortfall_kept", int'(bus1.remaining), 4);

        // saturating refill in IDLE
        @(posedge clk) #1;
        bus.refill = 1'b1; bus.refillCoin = 2'd3; bus.refillCount = 6'd60;
        @(posedge clk) #1 bus.refill = 1'b0;
        @(negedge clk);
        chk("refill_sat", int'(dut.stock[3]), 63);
        mstock[3] = 63;

        // refill ignored while busy
        @(posedge clk) #1 bus.coinAck = 1'b0;
        do_req(78);
        wait_coin();
        @(posedge clk) #1;
        bus.refill = 1'b1; bus.refillCoin = 2'd0; bus.refillCount = 6'd5;
        @(posedge clk) #1 bus.refill = 1'b0;
        @(negedge clk);
        chk("refill_busy_ignored", int'(dut.stock[0]), 10);
        chk("refill_busy_flag", int'(bus.busy), 1);
        pulse_reset();
        bus.coinAck = 1'b1;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Payout end of the ticket vending machine. Takes the change amount computed by `vending_machine` and pays it out one coin at a time to a coin hopper over a valid/ack handshake. Uses greedy denomination selection (50, 10, 5, 1) limited by an on-chip per-denomination coin inventory. Reports a fault with the unpaid shortfall when exact change cannot be made.

## Interface
- `INIT_STOCK`, default 10: coins of each denomination loaded into inventory at reset.
- `STOCK_W`, default 6: width of each inventory counter (max 63).
- `clk`  in  1: the block's single clock.
- `reset`  in  1: synchronous, active-high.
- `changeValid`  in  1: request strobe. Accepted only in IDLE; ignored otherwise.
- `changeAmount`  in  7: amount to pay (0–127). Sampled with `changeValid`.
- `refill`  in  1: inventory add strobe. Honoured only in IDLE with `changeValid` low.
- `refillCoin`  in  2: denomination to refill (0=1, 1=5, 2=10, 3=50).
- `refillCount`  in  STOCK_W: coins added, saturating at 2^STOCK_W−1.
- `coinAck`  in  1: hopper has dropped the presented coin.
- `coinValid`  out  1: a coin is presented.
- `coinType`  out  2: denomination code of the presented coin.
- `coinValue`  out  6: value of `coinType` (1/5/10/50).
- `busy`  out  1: high in every state except IDLE.
- `remaining`  out  7: amount still to pay.
- `done`  out  1: one-cycle completion pulse.
- `fault`  out  1: high together with `done` when `remaining` is not 0.
- `emptyMask`  out  4: bit i set when the denomination i inventory is 0.

## Operation
- States: IDLE, SELECT, DISPENSE, DONE.
- IDLE → SELECT when `changeValid` is high. `remaining` is loaded with `changeAmount`.
- IDLE refill: `stock[refillCoin] = min(stock + refillCount, 2^STOCK_W−1)`.
- If `changeValid` and `refill` are both high in IDLE, the request wins and the refill is dropped.
- SELECT picks the largest denomination d with `value(d) ≤ remaining` and `stock[d] > 0`.
  - `remaining == 0` → DONE, no fault.
  - No d qualifies → DONE with fault.
  - Otherwise latch d and go to DISPENSE.
- DISPENSE holds `coinValid` high with `coinType`/`coinValue` stable until `coinAck` is sampled high.
  - In the ack cycle: `remaining -= value(d)`, `stock[d] -= 1`, next state SELECT.
  - `coinAck` is ignored whenever `coinValid` is low.
- DONE: `done` is pulsed for one cycle; `fault = (remaining != 0)`. Next state IDLE.
- `remaining` keeps its final value in IDLE until the next request, so it reads as the shortfall after a fault.
- Arithmetic is unsigned. Subtraction never underflows because `value(d) ≤ remaining` is guaranteed by SELECT.
- Reset values:
  - state IDLE.
  - `coinValid`, `done`, `fault`, `busy` all 0.
  - `remaining` 0, `coinType` 0, `coinValue` 1.
  - every stock = INIT_STOCK.
  - `emptyMask` = 0 if INIT_STOCK > 0, else 4'b1111.
- Reset mid-operation:
  - the request is abandoned and no `done` is produced.
  - `coinValid` is low in the cycle after reset is sampled.
  - inventory is reinitialised to INIT_STOCK.

## Timing
- `changeValid` sampled in cycle N → SELECT in N+1 → `coinValid` first high in N+2.
- Ack in cycle M → SELECT in M+1 → next `coinValid` in M+2. Peak rate is one coin per 2 cycles with zero-wait ack.
- Zero change: `done` in N+2, no coins.
- The DONE cycle follows the last SELECT, so `done` is high in the cycle after the final ack + 1.
- All outputs are registered.

## Structure
- Package `change_pkg`:
  - coin type encoding.
  - `COIN_VALUE[4]` = {1, 5, 10, 50}.
  - state enum.
  - `CHANGE_W` = 7.
- Sub-module `coin_select`: combinational greedy picker.
  - Inputs: `remaining`, the 4 stock-nonzero flags.
  - Outputs: `found`, `coinType`.
  - Instantiated once by the SELECT logic.

## Test plan
- Default stock, change 5 → one coin type 1 (5); `done` with `fault` = 0; `remaining` 0; total request-to-`done` latency 5 cycles with immediate acks.
- Change 78 → coin sequence 50, 10, 10, 5, 1, 1, 1; stock50 = 9, stock10 = 8, stock5 = 9, stock1 = 7.
- INIT_STOCK = 1, change 20 → coins 10, 5, 1, then `done` with `fault` = 1, `remaining` = 4, `emptyMask` = 4'b0111.
- `coinAck` held low 3 cycles during a coin → `coinValid`/`coinType` stable for all 3 cycles; exactly one decrement when ack is seen.
- `reset` asserted while `coinValid` is high mid-78 payout → `coinValid` low next cycle, no `done`, stocks back to 10.
- Refill coin 3 with count 60 on default stock → stock50 saturates at 63. Refill asserted while `busy` is high → no change.
